popcnt_accum: RTL and testbench

POPCNT_ACCUM -- requirements
Module: popcnt_accum

---
 rtl/popcnt_accum.sv | 141 ++++++++++++++
 tb/tb_popcnt_accum.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/popcnt_accum.sv
// Accumulates per-word popcounts over a burst and presents the summed total,
// beat count and saturation/error flags with a valid/ready result handshake.
module popcnt_accum #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_count,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_total,
   output logic [WORD_WIDTH-1:0] out_words,
   output logic                  out_sat,
   output logic                  out_err
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned SUM_W = ((ACC_WIDTH > CNT_W) ? ACC_WIDTH : CNT_W) + 1;
   localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = '1;
   localparam logic [WORD_WIDTH-1:0] WORD_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_first;
   logic                  w_over;
   logic [CNT_W-1:0]      w_cnt_clamp;
   logic [ACC_WIDTH-1:0]  w_total_base;
   logic [WORD_WIDTH-1:0] w_words_base;
   logic [SUM_W-1:0]      w_sum;
   logic                  w_sum_sat;
   logic                  w_words_sat;
   logic [ACC_WIDTH-1:0]  w_total_nxt;
   logic [WORD_WIDTH-1:0] w_words_nxt;
   logic                  w_sat_nxt;
   logic                  w_err_nxt;

   logic [ACC_WIDTH-1:0]  r_total;
   logic [WORD_WIDTH-1:0] r_words;
   logic                  r_sat;
   logic                  r_err;
   logic                  r_out_valid;
   logic [ACC_WIDTH-1:0]  r_out_total;
   logic [WORD_WIDTH-1:0] r_out_words;
   logic                  r_out_sat;
   logic                  r_out_err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (enable) begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = in_last ? DONE : ACCUM;
         ACCUM:   if (w_accept && in_last) w_state_nxt = DONE;
         DONE:    if (enable && out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake outputs depend only on state and enable
   always_comb begin
      in_ready = 1'b0;
      w_accept = 1'b0;
      in_ready = enable && ((r_state == IDLE) || (r_state == ACCUM));
      w_accept = in_ready && in_valid;
   end

   // Clamp, accumulate and saturate; a beat in IDLE starts from zero
   always_comb begin
      w_first      = (r_state == IDLE);
      w_over       = (in_count > DATA_WIDTH'(DATA_WIDTH));
      w_cnt_clamp  = w_over ? CNT_W'(DATA_WIDTH) : CNT_W'(in_count);
      w_total_base = w_first ? '0 : r_total;
      w_words_base = w_first ? '0 : r_words;
      w_sum        = SUM_W'(w_total_base) + SUM_W'(w_cnt_clamp);
      w_sum_sat    = (w_sum > SUM_W'(ACC_MAX));
      w_words_sat  = (w_words_base == WORD_MAX);
      w_total_nxt  = w_sum_sat ? ACC_MAX : w_sum[ACC_WIDTH-1:0];
      w_words_nxt  = w_words_sat ? WORD_MAX : w_words_base + WORD_WIDTH'(1);
      w_sat_nxt    = (!w_first && r_sat) || w_sum_sat || w_words_sat;
      w_err_nxt    = (!w_first && r_err) || w_over;
   end

   // Running accumulators plus result registers captured on the last beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_total     <= '0;
         r_words     <= '0;
         r_sat       <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_total <= '0;
         r_out_words <= '0;
         r_out_sat   <= 1'b0;
         r_out_err   <= 1'b0;
      end else if (enable) begin
         if (w_accept) begin
            r_total <= w_total_nxt;
            r_words <= w_words_nxt;
            r_sat   <= w_sat_nxt;
            r_err   <= w_err_nxt;
            if (in_last) begin
               r_out_valid <= 1'b1;
               r_out_total <= w_total_nxt;
               r_out_words <= w_words_nxt;
               r_out_sat   <= w_sat_nxt;
               r_out_err   <= w_err_nxt;
            end
         end else if ((r_state == DONE) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_total = r_out_total;
   assign out_words = r_out_words;
   assign out_sat   = r_out_sat;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: a default instance plus a 9-bit-total
// instance sharing the same stimulus, used for the saturation case.
module tb_popcnt_accum;

   localparam int unsigned DW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          in_valid;
   logic [DW-1:0] in_count;
   logic          in_last;
   logic          out_ready;

   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_total;
   logic [15:0]   out_words;
   logic          out_sat;
   logic          out_err;

   logic          in_ready9;
   logic          out_valid9;
   logic [8:0]    out_total9;
   logic [15:0]   out_words9;
   logic          out_sat9;
   logic          out_err9;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   popcnt_accum dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
      .out_words(out_words), .out_sat(out_sat), .out_err(out_err)
   );

   popcnt_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(9), .WORD_WIDTH(16)) dut9 (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready9), .in_count(in_count), .in_last(in_last),
      .out_valid(out_valid9), .out_ready(out_ready), .out_total(out_total9),
      .out_words(out_words9), .out_sat(out_sat9), .out_err(out_err9)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int cnt, input logic last);
      in_valid = 1'b1;
      in_count = DW'(cnt);
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_count = '0;
      in_last = 1'b0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_total", out_total, 0);
      chk("rst_words", 32'(out_words), 0);
      chk("rst_flags", {30'd0, out_sat, out_err}, 0);
      chk("rst_ready", 32'(in_ready), 1);

      // Single beat
      beat(37, 1'b1);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_total", out_total, 37);
      chk("single_words", 32'(out_words), 1);
      chk("single_flags", {30'd0, out_sat, out_err}, 0);
      chk("single_ready_done", 32'(in_ready), 0);
      handshake();
      chk("single_release", 32'(out_valid), 0);
      chk("single_idle_ready", 32'(in_ready), 1);
      chk("single_hold_total", out_total, 37);

      // Three-beat burst with gaps
      beat(256, 1'b0);
      step(); step();
      chk("burst_accum_valid", 32'(out_valid), 0);
      chk("burst_accum_hold", out_total, 37);
      beat(0, 1'b0);
      step();
      beat(100, 1'b1);
      chk("burst_valid", 32'(out_valid), 1);
      chk("burst_total", out_total, 356);
      chk("burst_words", 32'(out_words), 3);
      chk("burst_ready_done", 32'(in_ready), 0);

      // Backpressure: an offered beat must not be taken while DONE
      in_valid = 1'b1; in_count = DW'(5); in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_total", out_total, 356);
         chk("bp_words", 32'(out_words), 3);
         chk("bp_ready", 32'(in_ready), 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      handshake();
      chk("bp_release_valid", 32'(out_valid), 0);
      chk("bp_release_ready", 32'(in_ready), 1);

      // Oversized count is clamped and flagged
      beat(300, 1'b1);
      chk("err_total", out_total, 256);
      chk("err_err", 32'(out_err), 1);
      chk("err_sat", 32'(out_sat), 0);
      chk("err_words", 32'(out_words), 1);
      handshake();

      // Saturation of a 9-bit total
      beat(256, 1'b0);
      beat(256, 1'b1);
      chk("sat9_valid", 32'(out_valid9), 1);
      chk("sat9_total", 32'(out_total9), 511);
      chk("sat9_sat", 32'(out_sat9), 1);
      chk("sat9_words", 32'(out_words9), 2);
      chk("sat9_err", 32'(out_err9), 0);
      chk("sat32_total", out_total, 512);
      chk("sat32_sat", 32'(out_sat), 0);
      handshake();

      // Reset mid-burst discards it, including a sticky error
      beat(300, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_total", out_total, 0);
      chk("mrst_words", 32'(out_words), 0);
      chk("mrst_flags", {30'd0, out_sat, out_err}, 0);
      chk("mrst_ready", 32'(in_ready), 1);
      beat(10, 1'b1);
      chk("mrst_new_total", out_total, 10);
      chk("mrst_new_words", 32'(out_words), 1);
      chk("mrst_new_err", 32'(out_err), 0);
      handshake();

      // Enable low mid-burst: nothing accepted, state holds
      beat(20, 1'b0);
      enable = 1'b0;
      in_valid = 1'b1; in_count = DW'(99); in_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("en_ready", 32'(in_ready), 0);
         chk("en_valid", 32'(out_valid), 0);
         chk("en_total_hold", out_total, 10);
      end
      enable = 1'b1;
      in_valid = 1'b0; in_last = 1'b0;
      beat(30, 1'b1);
      chk("en_total", out_total, 50);
      chk("en_words", 32'(out_words), 2);
      chk("en_valid_done", 32'(out_valid), 1);

      // Enable low while DONE with out_ready high keeps the result
      enable = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("en_done_hold", 32'(out_valid), 1);
      enable = 1'b1;
      step();
      out_ready = 1'b0;
      chk("en_done_release", 32'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
